i2s_rx_master: RTL and testbench

I2S receive front end and bus clock master for the simulated-audio datapath. It divides `mclk_in` to generate `I2S_bclk_out` and `I2S_wclk_out` and deserializes `I2S_din0` into parallel left/right samples. It presents one stereo pair per frame to the downstream processing chain. It is the receiving, clock-owning end of the link whose transmitter shifts one bit per falling `bclk`.

---
 rtl/i2s_pkg.sv | 10 +
 rtl/i2s_clk_gen.sv | 49 ++++
 rtl/i2s_rx_master.sv | 76 +++++++
 tb/tb_i2s_rx_master.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// i2s_pkg: shared state type, word-select constants and parameter legality check
// for the I2S receive master.
package i2s_pkg;
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;
  localparam logic WCLK_LEFT = 1'b0;
  localparam logic WCLK_RIGHT = 1'b1;
  function automatic bit params_ok(input int width, input int slot_bits, input int bclk_div);
    return (bclk_div % 2 == 0) && (bclk_div >= 2) && (slot_bits >= width);
  endfunction
endpackage

// File: rtl/i2s_clk_gen.sv
// i2s_clk_gen: divides mclk into bclk, counts bits per slot and toggles wclk at slot wrap.
module i2s_clk_gen
  import i2s_pkg::*;
#(
  parameter int SLOT_BITS = 32,
  parameter int BCLK_DIV  = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         run,
  output logic                         bclk,
  output logic                         wclk,
  output logic                         rise,
  output logic                         fall,
  output logic [$clog2(SLOT_BITS)-1:0] bit_cnt
);
  localparam int DW = $clog2(BCLK_DIV);
  localparam int BW = $clog2(SLOT_BITS);
  localparam logic [DW-1:0] HALF = DW'(BCLK_DIV / 2);
  localparam logic [DW-1:0] DIV_MAX = DW'(BCLK_DIV - 1);
  localparam logic [BW-1:0] BIT_MAX = BW'(SLOT_BITS - 1);
  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic bclk_q, bclk_d, wclk_q, wclk_d;
  // Strobes flag the edge at which bclk changes, so actions keyed on them coincide with it.
  always_comb begin
    rise = run && div_cnt_q == HALF;
    fall = run && div_cnt_q == '0 && bclk_q;
    div_cnt_d = !run ? '0 : div_cnt_q == DIV_MAX ? '0 : div_cnt_q + DW'(1);
    bclk_d = run && div_cnt_q >= HALF;
    bit_cnt_d = !run ? '0 : !fall ? bit_cnt_q : bit_cnt_q == BIT_MAX ? '0 : bit_cnt_q + BW'(1);
    wclk_d = !run ? WCLK_LEFT : (fall && bit_cnt_q == BIT_MAX) ? !wclk_q : wclk_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
      bclk_q <= 1'b0;
      wclk_q <= WCLK_LEFT;
    end else begin
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      bclk_q <= bclk_d;
      wclk_q <= wclk_d;
    end
  assign bclk = bclk_q;
  assign wclk = wclk_q;
  assign bit_cnt = bit_cnt_q;
endmodule

// File: rtl/i2s_rx_master.sv
// i2s_rx_master: I2S clock master and receiver, one stereo pair per frame.
// Define I2S_RX_LSB_FIRST_EN for LSB-first slot mapping (MSB-first otherwise).
module i2s_rx_master
  import i2s_pkg::*;
#(
  parameter int WIDTH     = 24,
  parameter int SLOT_BITS = 32,
  parameter int BCLK_DIV  = 8
) (
  input  logic             mclk_in,
  input  logic             rst_n,
  input  logic             en,
  input  logic             I2S_din0,
  output logic             I2S_bclk_out,
  output logic             I2S_wclk_out,
  output logic [WIDTH-1:0] left_data,
  output logic [WIDTH-1:0] right_data,
  output logic             sample_valid
);
  localparam int BW = $clog2(SLOT_BITS);
  localparam logic [BW-1:0] BIT_MAX = BW'(SLOT_BITS - 1);
  if (!params_ok(WIDTH, SLOT_BITS, BCLK_DIV)) begin : g_bad_params
    $error("i2s_rx_master: illegal WIDTH/SLOT_BITS/BCLK_DIV");
  end
  state_e state_q, state_d;
  logic first_q, first_d, stop_q, stop_d, valid_q, valid_d;
  logic [WIDTH-1:0] shift_q, shift_d, left_q, left_d, right_q, right_d, shifted;
  logic [BW-1:0] bit_cnt, slot_bit;
  logic bclk, wclk, rise, fall, boundary, take, done;
  i2s_clk_gen #(.SLOT_BITS(SLOT_BITS), .BCLK_DIV(BCLK_DIV)) u_clk_gen (
    .clk(mclk_in), .rst_n(rst_n), .run(state_q == RUN),
    .bclk(bclk), .wclk(wclk), .rise(rise), .fall(fall), .bit_cnt(bit_cnt)
  );
`ifdef I2S_RX_LSB_FIRST_EN
  assign shifted = WIDTH'({I2S_din0, shift_q} >> 1);
`else
  assign shifted = WIDTH'({shift_q, I2S_din0});
`endif
  // One-bit delay: the rise at bit_cnt k carries slot bit k-1, rise 0 carries the previous slot's last bit.
  always_comb begin
    slot_bit = bit_cnt == '0 ? BIT_MAX : bit_cnt - BW'(1);
    boundary = rise && bit_cnt == '0;
    take = rise && int'(slot_bit) < WIDTH;
    shift_d = take ? shifted : shift_q;
    done = boundary && !first_q;
    state_d = state_q == IDLE ? (en ? RUN : IDLE) : (fall && stop_q ? IDLE : RUN);
    first_d = state_q == IDLE || (first_q && !rise);
    stop_d = state_q == IDLE ? 1'b0 : (boundary && wclk == WCLK_LEFT) ? !en : stop_q;
    left_d = (done && wclk == WCLK_RIGHT) ? shift_d : left_q;
    right_d = (done && wclk == WCLK_LEFT) ? shift_d : right_q;
    valid_d = done && wclk == WCLK_LEFT;
  end
  always_ff @(posedge mclk_in or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      first_q <= 1'b1;
      stop_q <= 1'b0;
      shift_q <= '0;
      left_q <= '0;
      right_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      first_q <= first_d;
      stop_q <= stop_d;
      shift_q <= shift_d;
      left_q <= left_d;
      right_q <= right_d;
      valid_q <= valid_d;
    end
  assign I2S_bclk_out = bclk;
  assign I2S_wclk_out = wclk;
  assign left_data = left_q;
  assign right_data = right_q;
  assign sample_valid = valid_q;
endmodule

// File: tb/tb_i2s_rx_master.sv
// tb_i2s_rx_master: transmitter driven off the DUT clocks, checked every cycle against a
// time-indexed model of the frame schedule plus literal expectations for the directed cases.
`timescale 1ns/1ps
module tb_i2s_rx_master;
  localparam int W = 24, SB = 32, DIV = 8;
  localparam int FRAME = 2 * SB * DIV;
  logic mclk = 1'b0, rst_n = 1'b1, en = 1'b0, din = 1'b0;
  logic bclk, wclk, valid;
  logic [W-1:0] left, right;
  int n_chk = 0, n_pass = 0, cyc_n = 0, tx_mode = 0, tx_f = 0;
  logic [W-1:0] samp [64];
  logic [SB-W-1:0] pad [64];
  logic m_run, stop_pend, e_bclk, e_wclk, e_valid;
  logic [W-1:0] e_left, e_right;

  i2s_rx_master #(.WIDTH(W), .SLOT_BITS(SB), .BCLK_DIV(DIV)) dut (
    .mclk_in(mclk), .rst_n(rst_n), .en(en), .I2S_din0(din),
    .I2S_bclk_out(bclk), .I2S_wclk_out(wclk),
    .left_data(left), .right_data(right), .sample_valid(valid)
  );

  always #5 mclk = ~mclk;

  initial forever begin
    @(posedge mclk);
    cyc_n++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic tx_bit(input logic [W-1:0] smp, input logic [SB-W-1:0] pd, input int j);
    if (j >= W) return pd[j-W];
`ifdef I2S_RX_LSB_FIRST_EN
    return smp[j];
`else
    return smp[W-1-j];
`endif
  endfunction

  // Transmitter: the n-th bclk fall since the link started drives slot n/SB, bit n%SB.
  initial begin
    int low, s, j;
    logic pb;
    low = 0;
    pb = 1'b0;
    forever begin
      @(posedge mclk);
      #1;
      if (!rst_n) begin
        tx_f = 0; low = 0; pb = 1'b0; din = 1'b0;
      end else begin
        low = bclk ? 0 : low + 1;
        if (low > DIV / 2 + 1) tx_f = 0;
        if (pb && !bclk) begin
          s = tx_f / SB;
          j = tx_f % SB;
          tx_f++;
          if (j == 0) begin
            samp[s%64] = tx_mode == 2 ? W'($urandom) : tx_mode == 1 ? (s % 2 == 1 ? 24'h800000 : 24'h000001)
                       : (s % 2 == 1 ? 24'h123456 : 24'hA5C3F0);
            pad[s%64] = tx_mode == 1 ? '1 : (SB-W)'($urandom);
          end
          din = tx_bit(samp[s%64], pad[s%64], j);
        end
        pb = bclk;
      end
    end
  end

  // Model: k counts mclk edges since the run began; every output follows from k arithmetic.
  initial begin
    int k, r, s;
    k = 0;
    forever begin
      @(posedge mclk or negedge rst_n);
      if (!rst_n) begin
        m_run = 0; k = 0; stop_pend = 0;
        e_bclk = 0; e_wclk = 0; e_valid = 0; e_left = '0; e_right = '0;
      end else if (!m_run) begin
        e_valid = 0;
        if (en) begin m_run = 1; k = 0; stop_pend = 0; end
      end else begin
        k++;
        e_valid = 0;
        e_bclk = ((k - 1) % DIV) >= DIV / 2;
        e_wclk = (((k - 1) / (SB * DIV)) % 2) == 1;
        if (k > DIV / 2 && (k - DIV / 2 - 1) % DIV == 0) begin
          r = (k - DIV / 2 - 1) / DIV;
          if (r > 0 && r % SB == 0) begin
            s = r / SB - 1;
            if (s % 2 == 0) e_left = samp[s%64];
            else begin e_right = samp[s%64]; e_valid = 1; end
          end
          if (r % (2 * SB) == 0) stop_pend = !en;
        end
        if (k > 1 && k % DIV == 1 && stop_pend) begin m_run = 0; e_bclk = 0; e_wclk = 0; end
      end
    end
  end

  initial forever begin
    @(negedge mclk);
    check("bclk", bclk, e_bclk);
    check("wclk", wclk, e_wclk);
    check("sample_valid", valid, e_valid);
    check("left_data", left, e_left);
    check("right_data", right, e_right);
  end

  task automatic wait_valid(output int stamp);
    int n;
    n = 0;
    do begin @(negedge mclk); n++; end while (valid !== 1'b1 && n < 2 * FRAME);
    check("valid_seen", valid, 1);
    stamp = cyc_n;
  endtask

  initial begin
    int t0, t1, n, tog, hi;
    logic pv;
    t0 = 0;
    #1 rst_n = 1'b0;
    repeat (5) @(negedge mclk);
    check("rst_bclk", bclk, 0);
    check("rst_left", left, 0);
    check("rst_valid", valid, 0);
    rst_n = 1'b1;
    tog = 0;
    pv = bclk;
    repeat (1000) begin
      @(negedge mclk);
      if (bclk !== pv) tog++;
      pv = bclk;
    end
    check("idle_bclk_toggles", tog, 0);
    // en raised between edges: seen at the next edge, first rise BCLK_DIV/2+1 edges later
    tx_mode = 0;
    en = 1'b1;
    n = 0;
    while (bclk !== 1'b1 && n < 50) begin @(posedge mclk); #1; n++; end
    check("first_rise_cycles", n, DIV / 2 + 2);
    for (int i = 0; i < 3; i++) begin
      wait_valid(t1);
      check("msb_left", left, 24'hA5C3F0);
      check("msb_right", right, 24'h123456);
      if (i > 0) check("frame_period", t1 - t0, FRAME);
      t0 = t1;
    end
    tx_mode = 1;
    for (int i = 0; i < 2; i++) begin
      wait_valid(t1);
      check("pad_left", left, 24'h000001);
      check("pad_right", right, 24'h800000);
    end
    tx_mode = 0;
    wait_valid(t1);
    repeat (FRAME / 4) @(negedge mclk);
    en = 1'b0;
    wait_valid(t1);
    check("stop_left", left, 24'hA5C3F0);
    check("stop_right", right, 24'h123456);
    repeat (2 * DIV) @(negedge mclk);
    hi = 0;
    repeat (1500) begin
      @(negedge mclk);
      if (bclk || wclk || valid) hi++;
    end
    check("stop_quiet_cycles", hi, 0);
    en = 1'b1;
    for (int i = 0; i < 2; i++) wait_valid(t1);
    check("restart_left", left, 24'hA5C3F0);
    check("restart_right", right, 24'h123456);
    n = 0;
    while (tx_f % (2 * SB) != SB + 10 && n < 2 * FRAME) begin @(negedge mclk); n++; end
    check("pre_reset_wclk", wclk, 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_bclk", bclk, 0);
    check("midrst_wclk", wclk, 0);
    check("midrst_left", left, 0);
    check("midrst_right", right, 0);
    check("midrst_valid", valid, 0);
    repeat (3) @(posedge mclk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      wait_valid(t1);
      check("post_rst_left", left, 24'hA5C3F0);
      check("post_rst_right", right, 24'h123456);
    end
    tx_mode = 2;
    repeat (16000) begin
      @(negedge mclk);
      if ($urandom_range(0, 999) == 0) en = !en;
    end
    en = 1'b0;
    repeat (4) @(negedge mclk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
